// File: rtl/seq_signed_bcd_7seg_if.sv
// ---------------------------------------------------------------------------
// seq_signed_bcd_7seg_if
// Bundles the request and display signals of the signed binary to 7-segment
// converter.
//   start     : request a conversion (seen by the converter only when idle)
//   binary    : value to convert, captured on the accepted start cycle
//   busy      : conversion in progress
//   done      : one-cycle pulse when new display values appear
//   seg       : DIGITS x 7 active-low segments {g,f,e,d,c,b,a}, ones digit lowest
//   sign_seg  : active-low sign display (minus or blank)
//   overflow  : last magnitude did not fit in DIGITS decimal digits
// master = requester side, slave = converter side.
// ---------------------------------------------------------------------------
interface seq_signed_bcd_7seg_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      binary;
  logic                  busy;
  logic                  done;
  logic [DIGITS*7-1:0]   seg;
  logic [6:0]            sign_seg;
  logic                  overflow;

  modport master (
    output start, binary,
    input  busy, done, seg, sign_seg, overflow
  );

  modport slave (
    input  start, binary,
    output busy, done, seg, sign_seg, overflow
  );
endinterface

// File: rtl/seq_signed_bcd_7seg.sv
// ---------------------------------------------------------------------------
// seq_signed_bcd_7seg
// Sequential binary to signed decimal 7-segment converter. A request captures
// the magnitude and sign of the input, runs WIDTH double-dabble steps on a
// BCD accumulator one DIGITS+1 nibbles wide, then loads the segment, sign
// and overflow displays in a single cycle and pulses done.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seq_signed_bcd_7seg_if slave (start/binary in, busy/done/displays out)
// Parameters: WIDTH (4..16), DIGITS (1..5), SIGNED_MODE, BLANK_LZ.
// ---------------------------------------------------------------------------
module seq_signed_bcd_7seg #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int SIGNED_MODE = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_signed_bcd_7seg_if.slave  bus
);

  localparam int ACC_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    mag_q;
  logic                neg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ACC_W-1:0]    acc_q;
  logic                spill_q;
  logic                busy_q;
  logic                done_q;
  logic [DIGITS*7-1:0] seg_q;
  logic [6:0]          sign_q;
  logic                ovf_q;

  logic                capt_neg_d;
  logic [WIDTH-1:0]    capt_mag_d;
  logic [ACC_W-1:0]    acc_dab_d;
  logic [DIGITS*7-1:0] seg_d;
  logic                ovf_d;
  logic [3:0]          nib_d;
  logic                lead_d;

  // Add-3 correction on every nibble that is 5 or more, ahead of the shift.
  function automatic logic [ACC_W-1:0] dabble_adjust(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = a[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern of one BCD digit.
  function automatic logic [6:0] enc7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Sign and magnitude of the value being requested; the negation is done
  // in WIDTH unsigned bits so the most negative input maps to 2^(WIDTH-1).
  always_comb begin
    capt_neg_d = 1'b0;
    capt_mag_d = bus.binary;
    if ((SIGNED_MODE != 0) && bus.binary[WIDTH-1]) begin
      capt_neg_d = 1'b1;
      capt_mag_d = (~bus.binary) + WIDTH'(1);
    end else begin
      capt_neg_d = 1'b0;
      capt_mag_d = bus.binary;
    end
  end

  assign acc_dab_d = dabble_adjust(acc_q);

  // Display decode of the finished accumulator: overflow dashes, leading
  // zero blanking scanned from the top digit down, ones digit always shown.
  // spill_q catches magnitudes that ran past even the extra nibble.
  always_comb begin
    seg_d  = '0;
    nib_d  = 4'd0;
    lead_d = 1'b1;
    ovf_d  = spill_q | (acc_q[ACC_W-1 -: 4] != 4'd0);
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib_d = acc_q[4*i +: 4];
      if (ovf_d) begin
        seg_d[7*i +: 7] = SEG_DASH;
      end else if ((BLANK_LZ != 0) && lead_d && (nib_d == 4'd0) && (i != 0)) begin
        seg_d[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_d[7*i +: 7] = enc7(nib_d);
      end
      if (nib_d != 4'd0) begin
        lead_d = 1'b0;
      end else begin
        lead_d = lead_d;
      end
    end
  end

  // Conversion FSM with registered status and display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      spill_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= '1;
      sign_q  <= SEG_BLANK;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mag_q   <= capt_mag_d;
            neg_q   <= capt_neg_d;
            cnt_q   <= CNT_W'(WIDTH - 1);
            acc_q   <= '0;
            spill_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          spill_q <= spill_q | acc_dab_d[ACC_W-1];
          acc_q   <= {acc_dab_d[ACC_W-2:0], mag_q[WIDTH-1]};
          mag_q   <= {mag_q[WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            state_q <= LOAD;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
            state_q <= SHIFT;
          end
        end
        LOAD: begin
          seg_q   <= seg_d;
          sign_q  <= neg_q ? SEG_DASH : SEG_BLANK;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.seg      = seg_q;
  assign bus.sign_seg = sign_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seq_signed_bcd_7seg.sv
// ---------------------------------------------------------------------------
// tb_seq_signed_bcd_7seg
// Four converters (default, no blanking, unsigned, two digits) share one
// request stream. Expected displays come from a decimal arithmetic model and
// are queued per converter with the cycle on which done must appear.
// ---------------------------------------------------------------------------
module tb_seq_signed_bcd_7seg;
  localparam int W = 8;

  typedef struct {
    logic [34:0] seg;
    logic [6:0]  sign;
    logic        ovf;
    longint      cyc;
  } exp_t;

  localparam logic [6:0] ENC [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_s = 1'b0;
  logic [W-1:0] bin_s = '0;
  longint       cyc = 0;
  longint       next_free = 0;
  int           n_cmp = 0;
  int           n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_signed_bcd_7seg_if #(.WIDTH(W), .DIGITS(3)) if0 ();
  seq_signed_bcd_7seg_if #(.WIDTH(W), .DIGITS(3)) if1 ();
  seq_signed_bcd_7seg_if #(.WIDTH(W), .DIGITS(3)) if2 ();
  seq_signed_bcd_7seg_if #(.WIDTH(W), .DIGITS(2)) if3 ();

  assign if0.start = start_s;  assign if0.binary = bin_s;
  assign if1.start = start_s;  assign if1.binary = bin_s;
  assign if2.start = start_s;  assign if2.binary = bin_s;
  assign if3.start = start_s;  assign if3.binary = bin_s;

  seq_signed_bcd_7seg #(.WIDTH(W), .DIGITS(3), .SIGNED_MODE(1), .BLANK_LZ(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  seq_signed_bcd_7seg #(.WIDTH(W), .DIGITS(3), .SIGNED_MODE(1), .BLANK_LZ(0))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  seq_signed_bcd_7seg #(.WIDTH(W), .DIGITS(3), .SIGNED_MODE(0), .BLANK_LZ(1))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  seq_signed_bcd_7seg #(.WIDTH(W), .DIGITS(2), .SIGNED_MODE(1), .BLANK_LZ(1))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Reference: decimal digits of the magnitude by division, then display rules.
  function automatic exp_t model(input logic [W-1:0] raw, input int sm, input int dg,
                                 input int blz, input longint c);
    exp_t e;
    bit   neg;
    int   mag;
    neg    = (sm != 0) && raw[W-1];
    mag    = neg ? (256 - int'(raw)) : int'(raw);
    e.ovf  = (mag >= pow10(dg));
    e.sign = neg ? 7'b0111111 : 7'b1111111;
    e.seg  = '0;
    e.cyc  = c;
    for (int i = 0; i < dg; i++) begin
      if (e.ovf)                              e.seg[7*i +: 7] = 7'b0111111;
      else if ((blz != 0) && (i > 0) && (mag < pow10(i))) e.seg[7*i +: 7] = 7'b1111111;
      else                                    e.seg[7*i +: 7] = ENC[(mag / pow10(i)) % 10];
    end
    return e;
  endfunction

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_reset_all();
    cmp("rst_busy0", 64'(if0.busy), 64'd0);      cmp("rst_done0", 64'(if0.done), 64'd0);
    cmp("rst_ovf0",  64'(if0.overflow), 64'd0);  cmp("rst_sign0", 64'(if0.sign_seg), 64'h7F);
    cmp("rst_seg0",  64'(if0.seg), 64'h1FFFFF);
    cmp("rst_busy1", 64'(if1.busy), 64'd0);      cmp("rst_seg1",  64'(if1.seg), 64'h1FFFFF);
    cmp("rst_busy2", 64'(if2.busy), 64'd0);      cmp("rst_seg2",  64'(if2.seg), 64'h1FFFFF);
    cmp("rst_busy3", 64'(if3.busy), 64'd0);      cmp("rst_done3", 64'(if3.done), 64'd0);
    cmp("rst_ovf3",  64'(if3.overflow), 64'd0);  cmp("rst_sign3", 64'(if3.sign_seg), 64'h7F);
    cmp("rst_seg3",  64'(if3.seg), 64'h3FFF);
  endtask

  // Drive one request slot; an accepted start schedules results on all four.
  task automatic issue(input bit st, input logic [W-1:0] b);
    longint e_n;
    start_s = st;
    bin_s   = b;
    e_n     = cyc + 1;
    if (st && !rst && (e_n >= next_free)) begin
      next_free = e_n + W + 2;
      q0.push_back(model(b, 1, 3, 1, e_n + W + 1));
      q1.push_back(model(b, 1, 3, 0, e_n + W + 1));
      q2.push_back(model(b, 0, 3, 1, e_n + W + 1));
      q3.push_back(model(b, 1, 2, 1, e_n + W + 1));
    end
  endtask

  task automatic step(input bit st, input logic [W-1:0] b);
    @(posedge clk);
    #2;
    issue(st, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, bin_s);
  endtask

  task automatic conv(input logic [W-1:0] b);
    step(1'b1, b);
    idle(W + 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    start_s = 1'b0;
    rst     = 1'b1;
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    #1;
    check_reset_all();
    idle(2);
    @(posedge clk);
    #2;
    rst       = 1'b0;
    next_free = 0;
  endtask

  task automatic check_done(input int k, input logic [34:0] s, input logic [6:0] sg,
                            input logic ov);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
      1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
      2: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
      3: if (q3.size() > 0) begin have = 1'b1; e = q3.pop_front(); end
      default: have = 1'b0;
    endcase
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL unexpected_done dut%0d at cyc %0d", k, cyc);
    end else if ((s !== e.seg) || (sg !== e.sign) || (ov !== e.ovf) || (cyc != e.cyc)) begin
      n_bad++;
      $display("FAIL result dut%0d got seg=%h sign=%b ovf=%b cyc=%0d want seg=%h sign=%b ovf=%b cyc=%0d",
               k, s, sg, ov, cyc, e.seg, e.sign, e.ovf, e.cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (if0.done === 1'b1) check_done(0, 35'(if0.seg), if0.sign_seg, if0.overflow);
      if (if1.done === 1'b1) check_done(1, 35'(if1.seg), if1.sign_seg, if1.overflow);
      if (if2.done === 1'b1) check_done(2, 35'(if2.seg), if2.sign_seg, if2.overflow);
      if (if3.done === 1'b1) check_done(3, 35'(if3.seg), if3.sign_seg, if3.overflow);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #3;
    check_reset_all();
    @(posedge clk);
    #2;
    rst       = 1'b0;
    next_free = 0;
    issue(1'b1, 8'h80);          // start in the very cycle reset is released
    idle(W + 1);

    conv(8'd5);
    conv(8'd0);
    conv(8'hFF);
    conv(8'd100);
    conv(8'd99);

    // Second start while busy is ignored; binary keeps changing meanwhile.
    step(1'b1, 8'd127);
    idle(2);
    step(1'b1, 8'hFF);
    step(1'b0, 8'h55);
    idle(W);
    conv(8'hFF);

    // Reset four cycles into a conversion: displays blank, no done.
    step(1'b1, 8'd200);
    idle(3);
    do_reset();
    #1;
    cmp("abort_busy", 64'(if0.busy), 64'd0);
    idle(W + 4);
    conv(8'd42);

    // Random traffic, start sometimes held, occasional reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) == 0), W'($urandom));
      end
    end
    idle(W + 4);

    cmp("drain_q0", 64'(q0.size()), 64'd0);
    cmp("drain_q1", 64'(q1.size()), 64'd0);
    cmp("drain_q2", 64'(q2.size()), 64'd0);
    cmp("drain_q3", 64'(q3.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
